// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-format defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a; used by uart_rx and uart_tx alike.
package uart_pkg;

    // bclk cycles per bit period and payload bits per frame
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
// Ports: clk (sampling clock), rst (sync active-high, forces both flops to
//        RESET_VAL), d (async input), q (synchronized output).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing, LSB first, break hold-off.
// Latency: rx_ready rises OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE bclk edges after IDLE sees the start edge.
// Backpressure: none; each good frame overwrites rx_dout with no consumer handshake.
// Ports: bclk (OVERSAMPLE x baud clock), rst (sync active-high), rxd (async line, idle high),
//        rx_dout (last good byte), rx_ready (1-cycle good-frame pulse),
//        rx_frame_err (1-cycle stop-low pulse), rx_busy (state != IDLE).
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_dout,
    output logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS  > 2) ? $clog2(DATA_BITS)  : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;

    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic                 stop_done;
    logic                 ready_d;
    logic                 err_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (bclk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // State register plus the registered output pulses and data latch.
    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_dout      <= '0;
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_ready     <= ready_d;
            rx_frame_err <= err_d;
            if (ready_d) begin
                rx_dout <= shift_q;
            end
        end
    end

    // Next-state logic. The start bit is checked half a bit in, so every later
    // sample taken one full bit period apart lands on a bit centre.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // a line already back high at mid-start was a glitch
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // hold here while the line stays low so a break gives one error
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; ready and error are mutually exclusive on rxd_s.
    always_comb begin
        stop_done = (state_q == STOP) && (cnt_q == FULL_LAST);
        ready_d   = stop_done &&  rxd_s;
        err_d     = stop_done && !rxd_s;
        rx_busy   = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default OVERSAMPLE=16, DATA_BITS=8.
// A negedge monitor counts output pulses and records received bytes; the
// initial block drives the line and checks against hand-computed values.
module tb_uart_rx;

    logic       bclk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_dout;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_busy;

    int tests = 0;
    int fails = 0;

    int cyc       = 0;
    int t_fall    = 0;
    int ready_cyc = 0;
    int ready_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    logic [7:0] got_q[$];

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .bclk         (bclk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_dout      (rx_dout),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    always @(posedge bclk) cyc <= cyc + 1;

    always @(negedge bclk) begin
        if (rx_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
            got_q.push_back(rx_dout);
        end
        if (rx_frame_err) err_cnt++;
        if (rx_ready && rx_frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives frame bits LSB first (bit 0 = start), 16 cycles per bit, for ncyc cycles.
    task automatic drive_line(input logic [9:0] bits, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge bclk); #1;
            rxd = bits[i/16];
            if (i == 0) t_fall = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge bclk); #1;
            rxd = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_line({1'b1, b, 1'b0}, 160);
    endtask

    initial begin
        int rc;
        int ec;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge bclk);
        #1 rst = 1'b0;

        // reset state
        check("reset_dout",  {24'd0, rx_dout}, 32'h00);
        check("reset_ready", {31'd0, rx_ready}, 32'd0);
        check("reset_err",   {31'd0, rx_frame_err}, 32'd0);
        check("reset_busy",  {31'd0, rx_busy}, 32'd0);
        idle(5);

        // single frame 0x0A; driven low at cycle N, 2 sync + 1 detect + 152 edges
        send_byte(8'h0A);
        idle(10);
        check("0a_count",   ready_cnt, 1);
        check("0a_dout",    {24'd0, rx_dout}, 32'h0A);
        check("0a_latency", ready_cyc - t_fall, 155);
        check("0a_err",     err_cnt, 0);

        // back-to-back frames, no idle gap
        send_byte(8'h55);
        send_byte(8'hA3);
        idle(10);
        check("b2b_count", ready_cnt, 3);
        check("b2b_first",  {24'd0, got_q[1]}, 32'h55);
        check("b2b_second", {24'd0, got_q[2]}, 32'hA3);
        check("b2b_err",    err_cnt, 0);

        // 4-cycle glitch: START returns to IDLE 7 edges after release
        rc = ready_cnt;
        drive_line(10'h000, 4);
        idle(1);
        check("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
        idle(7);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);
        check("glitch_ready", ready_cnt, rc);
        check("glitch_err",   err_cnt, 0);

        // 0xFF with stop low, then line held low 40 cycles (break)
        drive_line({1'b0, 8'hFF, 1'b0}, 160);
        repeat (40) @(posedge bclk);
        check("break_busy_held", {31'd0, rx_busy}, 32'd1);
        idle(10);
        check("break_err",   err_cnt, 1);
        check("break_ready", ready_cnt, rc);
        check("break_dout",  {24'd0, rx_dout}, 32'hA3);
        check("break_busy",  {31'd0, rx_busy}, 32'd0);

        // reset in the middle of data bit 4
        ec = err_cnt;
        drive_line({1'b1, 8'h3C, 1'b0}, 88);
        @(posedge bclk); #1 rst = 1'b1;
        @(posedge bclk); #1 rst = 1'b0;
        rxd = 1'b1;
        check("midrst_dout",  {24'd0, rx_dout}, 32'h00);
        check("midrst_ready", {31'd0, rx_ready}, 32'd0);
        check("midrst_busy",  {31'd0, rx_busy}, 32'd0);
        idle(30);
        check("midrst_nopulse", ready_cnt, rc);
        check("midrst_noerr",   err_cnt, ec);
        send_byte(8'h3C);
        idle(10);
        check("after_rst_count", ready_cnt, rc + 1);
        check("after_rst_dout",  {24'd0, rx_dout}, 32'h3C);

        // serial driver stands in for a transmitter: 0x00, 0x80, 0xFF
        send_byte(8'h00);
        idle(10);
        check("lb_00", {24'd0, rx_dout}, 32'h00);
        send_byte(8'h80);
        idle(10);
        check("lb_80", {24'd0, rx_dout}, 32'h80);
        send_byte(8'hFF);
        idle(10);
        check("lb_ff", {24'd0, rx_dout}, 32'hFF);
        check("lb_count", ready_cnt, rc + 4);

        check("never_both", both_cnt, 0);
        check("final_err",  err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning bclk cycles per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-003 SHALL have port bclk  input  1  sole clock, OVERSAMPLE x baud; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_dout  output  DATA_BITS  last correctly received byte.
REQ-007 SHALL have port rx_ready  output  1  one-cycle pulse: rx_dout newly valid.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer (rxd_s); all logic below uses rxd_s only.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit-period counter cnt and a bit index idx.
REQ-012 IDLE: on rxd_s==0 SHALL go to START with cnt=0; otherwise stay.
REQ-013 START: when cnt==OVERSAMPLE/2-1, SHALL go to DATA with cnt=0, idx=0 if rxd_s==0, else return to IDLE (glitch rejection, no output pulse).
REQ-014 DATA: when cnt==OVERSAMPLE-1, SHALL sample rxd_s into the shift register LSB first, reset cnt, and increment idx; after bit DATA_BITS-1 SHALL go to STOP.
REQ-015 STOP: when cnt==OVERSAMPLE-1 and rxd_s==1, SHALL load rx_dout from the shift register, pulse rx_ready for exactly one cycle, and go to IDLE.
REQ-016 STOP: when cnt==OVERSAMPLE-1 and rxd_s==0, SHALL leave rx_dout unchanged, pulse rx_frame_err for one cycle, and go to BREAK.
REQ-017 BREAK: SHALL stay until rxd_s==1, then go to IDLE, so that a held-low line yields exactly one error pulse.
REQ-018 Latency: rx_ready SHALL rise exactly OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE bclk edges (152 at defaults) after the edge on which IDLE first sees rxd_s==0.
REQ-019 All samples SHALL be taken at bit centres: mid-start, then every OVERSAMPLE cycles.
REQ-020 No output buffering: a later frame SHALL overwrite rx_dout, with no consumer handshake.
REQ-021 rx_ready and rx_frame_err SHALL never be high in the same cycle.
REQ-022 A falling edge during DATA or STOP SHALL be ignored; resynchronisation occurs only in IDLE.
REQ-023 rxd_s SHALL be able to go low on the same edge that STOP returns to IDLE, and the next frame SHALL then be detected on the following edge (back-to-back frames).

Reset
REQ-024 With rst high at a bclk edge, SHALL set state=IDLE, cnt=0, idx=0, shift register=0, rx_dout=0, rx_ready=0, rx_frame_err=0, rx_busy=0, and both synchronizer flops=1.
REQ-025 Reset mid-frame SHALL abort the frame with no output pulse; reception SHALL restart only on a new falling edge after rst is released.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state enumeration and the OVERSAMPLE and DATA_BITS defaults, shared with uart_tx.
REQ-027 The synchronizer SHALL be one sub-module, sync_2ff, reusable for other async inputs; the rest is flat.

Verification
REQ-028 Reset, then drive frame 0x0A (start, 0,1,0,1,0,0,0,0, stop) at 16 bclk per bit -> one rx_ready pulse, rx_dout=0x0A, 152 (+/-1) cycles after the falling edge crosses the synchronizer.
REQ-029 Send 0x55 then 0xA3 back-to-back with no idle gap -> two rx_ready pulses, rx_dout 0x55 then 0xA3, rx_frame_err never high.
REQ-030 Pull rxd low for 4 bclk only -> no pulse; rx_busy returns low within 8 cycles.
REQ-031 Send 0xFF with stop bit low, then hold rxd low for 40 cycles, then release high -> exactly one rx_frame_err pulse, rx_dout still holds the previous value, and BREAK is exited after release.
REQ-032 Assert rst for 1 cycle at mid-bit 4 of a frame -> all outputs reset, no pulse; the next complete 0x3C frame is received correctly.
REQ-033 Loopback: connect uart_tx txd to rxd on the same bclk and send 0x00, 0x80, 0xFF -> received byte equals sent byte for each.
